// File: rtl/spi_cmd_decoder.sv
// SPI mode-0 slave command decoder: validates 24-bit addr/data frames and emits one-cycle register strobes.
// Optional macro SPI_PARITY_CHECK_EN appends an even-parity bit to every frame.
`timescale 1ns/1ps

module spi_cmd_decoder #(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic [15:0] data_out,
    output logic [15:0] sel_out,
    output logic [3:0]  sel_dir_out,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        busy
);

`ifdef SPI_PARITY_CHECK_EN
    localparam int FRAME_LEN = FRAME_BITS + 1;
`else
    localparam int FRAME_LEN = FRAME_BITS;
`endif
    localparam int CNT_MAX = FRAME_LEN + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int NSYNC   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_UPDATE,
        S_ERROR
    } state_t;

    logic             r_rst_meta;
    logic             r_rst_n;
    logic [NSYNC-1:0] r_sck_sync;
    logic [NSYNC-1:0] r_cs_sync;
    logic [NSYNC-1:0] r_mosi_sync;
    logic             r_sck_prev;
    logic             r_cs_prev;
    state_t           r_state;
    state_t           w_next;
    logic [FRAME_LEN-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fall_pend;
    logic [15:0]      r_data;
    logic [7:0]       r_err_cnt;

    logic                  w_sck;
    logic                  w_cs;
    logic                  w_mosi;
    logic                  w_sck_rise;
    logic                  w_cs_rise;
    logic                  w_cs_fall;
    logic                  w_start;
    logic [FRAME_BITS-1:0] w_payload;
    logic [7:0]            w_addr;
    logic [15:0]           w_data;
    logic                  w_frame_ok;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    // cs_n resets to "low" so a frame already in progress at release produces no falling edge.
    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[NSYNC-2:0], spi_sck};
            r_cs_sync   <= {r_cs_sync[NSYNC-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[NSYNC-2:0], spi_mosi};
            r_sck_prev  <= r_sck_sync[NSYNC-1];
            r_cs_prev   <= r_cs_sync[NSYNC-1];
        end
    end

    assign w_sck      = r_sck_sync[NSYNC-1];
    assign w_cs       = r_cs_sync[NSYNC-1];
    assign w_mosi     = r_mosi_sync[NSYNC-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_cs_rise  = w_cs & ~r_cs_prev;
    assign w_cs_fall  = ~w_cs & r_cs_prev;
    assign w_start    = (r_state == S_IDLE) && (w_cs_fall || r_fall_pend);

`ifdef SPI_PARITY_CHECK_EN
    assign w_payload  = r_shift[FRAME_LEN-1:1];
    assign w_frame_ok = (r_cnt == CNT_W'(FRAME_LEN)) && (w_addr < 8'h14) && !(^r_shift);
`else
    assign w_payload  = r_shift;
    assign w_frame_ok = (r_cnt == CNT_W'(FRAME_LEN)) && (w_addr < 8'h14);
`endif
    assign w_addr = w_payload[FRAME_BITS-1 -: 8];
    assign w_data = w_payload[15:0];

    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall || r_fall_pend) w_next = S_SHIFT;
            S_SHIFT:  if (w_cs_rise) w_next = S_CHECK;
            S_CHECK:  w_next = w_frame_ok ? S_UPDATE : S_ERROR;
            S_UPDATE: w_next = S_IDLE;
            S_ERROR:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // A cs_n rise in the same sample as an sck rise closes the frame without shifting.
    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_fall_pend <= 1'b0;
            r_data      <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_shift     <= '0;
                r_cnt       <= '0;
                r_fall_pend <= 1'b0;
            end else if (w_cs_fall && (r_state != S_IDLE) && (r_state != S_SHIFT)) begin
                r_fall_pend <= 1'b1;
            end

            if ((r_state == S_SHIFT) && !w_cs_rise && w_sck_rise) begin
                r_shift <= {r_shift[FRAME_LEN-2:0], w_mosi};
                if (r_cnt != CNT_W'(CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (r_state == S_CHECK) begin
                if (w_frame_ok) begin
                    r_data <= w_data;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    // data_out is loaded leaving CHECK, so it is already new while the UPDATE strobe is high.
    always_comb begin
        sel_out     = '0;
        sel_dir_out = '0;
        frame_err   = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_UPDATE: begin
                if (w_addr[4]) begin
                    sel_dir_out[w_addr[1:0]] = 1'b1;
                end else begin
                    sel_out[w_addr[3:0]] = 1'b1;
                end
            end
            S_ERROR: frame_err = 1'b1;
            default: ;
        endcase
    end

    assign data_out = r_data;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed and random SPI frames against a frame-level model.
`timescale 1ns/1ps

module tb_spi_cmd_decoder;

    localparam int SYNC = 2;
`ifdef SPI_PARITY_CHECK_EN
    localparam int FLEN = 25;
`else
    localparam int FLEN = 24;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic [15:0] data_out;
    logic [15:0] sel_out;
    logic [3:0]  sel_dir_out;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_data = '0;
    logic [7:0]  exp_err = '0;

    int          obs_nstrobe;
    int          obs_lat;
    int          obs_nerr;
    logic [15:0] obs_sel;
    logic [3:0]  obs_dir;
    logic [15:0] obs_data;
    logic        obs_busy;

    spi_cmd_decoder #(.FRAME_BITS(24), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .data_out   (data_out),
        .sel_out    (sel_out),
        .sel_dir_out(sel_dir_out),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- frame-level reference model ----------------
`ifdef SPI_PARITY_CHECK_EN
    function automatic logic [31:0] mk(input logic [7:0] a, input logic [15:0] d);
        return {7'd0, a, d, ^{a, d}};
    endfunction
    function automatic logic [23:0] payload(input logic [31:0] w);
        return w[24:1];
    endfunction
`else
    function automatic logic [31:0] mk(input logic [7:0] a, input logic [15:0] d);
        return {8'd0, a, d};
    endfunction
    function automatic logic [23:0] payload(input logic [31:0] w);
        return w[23:0];
    endfunction
`endif

    function automatic bit frame_ok(input logic [31:0] w, input int n);
        logic [23:0] p;
        if (n != FLEN) return 1'b0;
`ifdef SPI_PARITY_CHECK_EN
        if (^w[24:0]) return 1'b0;
`endif
        p = payload(w);
        return p[23:16] < 8'h14;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = w[i];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int n);
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        obs_busy = busy;
        drive_bits(w, n);
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        obs_nstrobe = 0;
        obs_lat = 0;
        obs_nerr = 0;
        obs_sel = '0;
        obs_dir = '0;
        obs_data = data_out;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (sel_out != 16'd0 || sel_dir_out != 4'd0) begin
                obs_nstrobe++;
                obs_lat = k;
                obs_sel = sel_out;
                obs_dir = sel_dir_out;
                obs_data = data_out;
            end
            if (frame_err) obs_nerr++;
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({data_out, sel_out, sel_dir_out, frame_err, err_cnt, busy} !== 46'd0) begin
                errors++;
                $display("FAIL reset_outputs: got data=%h sel=%h dir=%h err=%b cnt=%h busy=%b, want all 0",
                         data_out, sel_out, sel_dir_out, frame_err, err_cnt, busy);
            end
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err_cnt !== 8'd0 || data_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b cnt=%h data=%h, want 0/00/0000", busy, err_cnt, data_out);
        end
    endtask

    task automatic test_directed();
        logic [31:0] tw[8];
        int          tn[8];
        logic [31:0] w;
        tw[0] = mk(8'h05, 16'h00A5);        tn[0] = FLEN;
        tw[1] = mk(8'h12, 16'h8003);        tn[1] = FLEN;
        tw[2] = mk(8'h20, 16'h1234);        tn[2] = FLEN;
        w = mk(8'h03, 16'h5555);
        tw[3] = w >> 1;                     tn[3] = FLEN - 1;
        tw[4] = {w[30:0], 1'b1};            tn[4] = FLEN + 1;
        tw[5] = mk(8'h00, 16'h7E81);        tn[5] = FLEN;
        tw[6] = '0;                         tn[6] = 0;
        tw[7] = mk(8'h13, 16'hFFFF);        tn[7] = FLEN;
        for (int t = 0; t < 8; t++) begin
            bit          ok;
            logic [23:0] p;
            logic [15:0] es;
            logic [3:0]  ed;
            send_frame(tw[t], tn[t]);
            ok = frame_ok(tw[t], tn[t]);
            p = payload(tw[t]);
            es = (ok && p[23:16] < 8'h10) ? (16'd1 << p[19:16]) : 16'd0;
            ed = (ok && p[23:16] >= 8'h10) ? (4'd1 << p[17:16]) : 4'd0;
            if (ok) exp_data = p[15:0];
            else if (exp_err != 8'hFF) exp_err++;
            checks++;
            if (obs_busy !== 1'b1) begin
                errors++; $display("FAIL dir%0d busy: got %b want 1", t, obs_busy);
            end
            checks++;
            if (obs_nstrobe !== int'(ok)) begin
                errors++; $display("FAIL dir%0d strobe_cycles: got %0d want %0d", t, obs_nstrobe, int'(ok));
            end
            checks++;
            if (obs_sel !== es || obs_dir !== ed) begin
                errors++; $display("FAIL dir%0d strobe: got sel=%h dir=%b want sel=%h dir=%b", t, obs_sel, obs_dir, es, ed);
            end
            if (ok) begin
                checks++;
                if (obs_lat !== SYNC + 2) begin
                    errors++; $display("FAIL dir%0d latency: got %0d want %0d", t, obs_lat, SYNC + 2);
                end
            end
            checks++;
            if (obs_nerr !== int'(!ok)) begin
                errors++; $display("FAIL dir%0d frame_err_pulses: got %0d want %0d", t, obs_nerr, int'(!ok));
            end
            checks++;
            if (obs_data !== exp_data || data_out !== exp_data || err_cnt !== exp_err) begin
                errors++; $display("FAIL dir%0d data/err_cnt: got %h/%h/%h want %h/%h", t, obs_data, data_out, err_cnt, exp_data, exp_err);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic [7:0]  a;
            logic [15:0] d;
            logic [31:0] w;
            int          n;
            int          r;
            bit          ok;
            logic [23:0] p;
            logic [15:0] es;
            logic [3:0]  ed;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8'h17));
            d = 16'($urandom);
            w = mk(a, d);
            n = FLEN;
            r = $urandom_range(0, 9);
            if (r == 7) begin w = w >> 1; n = FLEN - 1; end
            else if (r == 8) begin w = {w[30:0], 1'($urandom)}; n = FLEN + 1; end
            else if (r == 9) begin w = '0; n = 0; end
`ifdef SPI_PARITY_CHECK_EN
            else if (r == 6) w[0] = ~w[0];
`endif
            send_frame(w, n);
            ok = frame_ok(w, n);
            p = payload(w);
            es = (ok && p[23:16] < 8'h10) ? (16'd1 << p[19:16]) : 16'd0;
            ed = (ok && p[23:16] >= 8'h10) ? (4'd1 << p[17:16]) : 4'd0;
            if (ok) exp_data = p[15:0];
            else if (exp_err != 8'hFF) exp_err++;
            checks++;
            if (obs_nstrobe !== int'(ok) || obs_sel !== es || obs_dir !== ed) begin
                errors++; $display("FAIL rnd%0d strobe: got n=%0d sel=%h dir=%b want n=%0d sel=%h dir=%b",
                                   t, obs_nstrobe, obs_sel, obs_dir, int'(ok), es, ed);
            end
            if (ok) begin
                checks++;
                if (obs_lat !== SYNC + 2) begin
                    errors++; $display("FAIL rnd%0d latency: got %0d want %0d", t, obs_lat, SYNC + 2);
                end
            end
            checks++;
            if (obs_nerr !== int'(!ok) || data_out !== exp_data || err_cnt !== exp_err) begin
                errors++; $display("FAIL rnd%0d result: got err=%0d data=%h cnt=%h want err=%0d data=%h cnt=%h",
                                   t, obs_nerr, data_out, err_cnt, int'(!ok), exp_data, exp_err);
            end
        end
    endtask

`ifdef SPI_PARITY_CHECK_EN
    task automatic test_parity();
        logic [31:0] w;
        w = mk(8'h09, 16'hC3A1);
        send_frame(w, FLEN);
        exp_data = 16'hC3A1;
        checks++;
        if (obs_nstrobe !== 1 || obs_sel !== 16'h0200 || obs_nerr !== 0 || data_out !== exp_data) begin
            errors++; $display("FAIL parity_good: got n=%0d sel=%h err=%0d data=%h want 1/0200/0/%h",
                               obs_nstrobe, obs_sel, obs_nerr, data_out, exp_data);
        end
        w[0] = ~w[0];
        send_frame(w, FLEN);
        if (exp_err != 8'hFF) exp_err++;
        checks++;
        if (obs_nstrobe !== 0 || obs_nerr !== 1 || data_out !== exp_data || err_cnt !== exp_err) begin
            errors++; $display("FAIL parity_bad: got n=%0d err=%0d data=%h cnt=%h want 0/1/%h/%h",
                               obs_nstrobe, obs_nerr, data_out, err_cnt, exp_data, exp_err);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int n_str;
        int n_err;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        drive_bits(32'h00A5_5A5A, 12);
        rst_n = 1'b0;
        exp_data = '0;
        exp_err = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({data_out, sel_out, sel_dir_out, frame_err, err_cnt, busy} !== 46'd0) begin
                errors++; $display("FAIL midreset_outputs: got data=%h sel=%h dir=%h err=%b cnt=%h busy=%b, want all 0",
                                   data_out, sel_out, sel_dir_out, frame_err, err_cnt, busy);
            end
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL midreset_ignored_frame: got busy=%b want 0", busy);
        end
        spi_cs_n = 1'b1;
        n_str = 0;
        n_err = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (sel_out != 16'd0 || sel_dir_out != 4'd0) n_str++;
            if (frame_err) n_err++;
        end
        checks++;
        if (n_str !== 0 || n_err !== 0 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL midreset_abort: got strobes=%0d errs=%0d cnt=%h want 0/0/00", n_str, n_err, err_cnt);
        end
        send_frame(mk(8'h0F, 16'h0BEE), FLEN);
        exp_data = 16'h0BEE;
        checks++;
        if (obs_nstrobe !== 1 || obs_sel !== 16'h8000 || obs_dir !== 4'd0 || obs_lat !== SYNC + 2 || data_out !== exp_data) begin
            errors++; $display("FAIL midreset_next_frame: got n=%0d sel=%h dir=%b lat=%0d data=%h want 1/8000/0/%0d/%h",
                               obs_nstrobe, obs_sel, obs_dir, obs_lat, data_out, SYNC + 2, exp_data);
        end
    endtask

    task automatic test_saturation();
        int n_err;
        int n_str;
        n_err = 0;
        n_str = 0;
        for (int f = 0; f < 300; f++) begin
            @(negedge clk);
            spi_cs_n = 1'b0;
            repeat (6) @(negedge clk);
            spi_cs_n = 1'b1;
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                if (frame_err) n_err++;
                if (sel_out != 16'd0 || sel_dir_out != 4'd0) n_str++;
            end
            if (exp_err != 8'hFF) exp_err++;
        end
        checks++;
        if (n_err !== 300 || n_str !== 0) begin
            errors++; $display("FAIL sat_pulses: got errs=%0d strobes=%0d want 300/0", n_err, n_str);
        end
        checks++;
        if (err_cnt !== exp_err || err_cnt !== 8'hFF) begin
            errors++; $display("FAIL sat_err_cnt: got %h want %h", err_cnt, exp_err);
        end
        checks++;
        if (data_out !== exp_data) begin
            errors++; $display("FAIL sat_data_hold: got %h want %h", data_out, exp_data);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
`ifdef SPI_PARITY_CHECK_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Serial command front end that sits directly upstream of the output-register unit.
- Receives 24-bit address/data frames from the host controller over a mode-0 SPI slave link and validates each frame.
- Drives the 16-bit data word plus one-cycle select strobes for the 16 output-data registers and the 4 direction registers.
- Bit 15 of the data word is the downstream clear flag; this block passes it through unmodified.

Parameters:
- FRAME_BITS, 24, payload bits per frame: 8-bit address followed by 16-bit data, MSB first.
- SYNC_STAGES, 2, synchronizer flops on spi_sck, spi_cs_n and spi_mosi (minimum 2).

Ports:
- clk  input  1  system clock; frequency ≥ 4× spi_sck.
- rst_n  input  1  asynchronous active-low reset.
- spi_sck  input  1  serial clock, async to clk; sampled on rising edge.
- spi_cs_n  input  1  frame enable, active low, async.
- spi_mosi  input  1  serial data, async.
- data_out  output  16  last accepted data word.
- sel_out  output  16  one-hot, one-cycle strobe for output register 0..15.
- sel_dir_out  output  4  one-hot, one-cycle strobe for direction register 0..3.
- frame_err  output  1  one-cycle pulse for a rejected frame.
- err_cnt  output  8  saturating count of rejected frames.
- busy  output  1  high while a frame is in progress (synced cs_n low).

Behaviour:
- Reset (async assert, sync release) clears:
  - data_out=0x0000, sel_out=0, sel_dir_out=0
  - frame_err=0, err_cnt=0, busy=0
  - shift register, bit counter, FSM state = IDLE
- All three SPI inputs pass through SYNC_STAGES flops. Edge detection compares the last two synchronized samples.
- FSM:
  - IDLE: on synced cs_n falling edge → clear shift register and bit count, go to SHIFT.
  - SHIFT:
    - Each synced sck rising edge shifts mosi into the LSB and increments the bit count.
    - The count saturates at FRAME_BITS+1; any bit beyond FRAME_BITS is an overrun.
    - On synced cs_n rising edge → CHECK.
  - CHECK (1 cycle): the frame is valid iff bit count == FRAME_BITS and the address is mapped.
    - Valid → UPDATE.
    - Invalid → ERROR.
  - UPDATE (1 cycle), one cycle after CHECK:
    - data_out ← shift[15:0].
    - Address 0x00–0x0F asserts sel_out[addr]; 0x10–0x13 asserts sel_dir_out[addr-0x10].
    - The strobe and the new data_out are visible in the same cycle.
    - Return to IDLE.
  - ERROR (1 cycle): frame_err=1, err_cnt+1 saturating at 0xFF, data_out unchanged, no strobe. Return to IDLE.
- Address map: 0x14–0xFF is unmapped and causes ERROR.
- Short frames (<24 bits) and overrun frames (>24 bits) cause ERROR.
- A frame with zero sck edges also causes ERROR.
- Latency: the strobe appears exactly 2 clk cycles after the synced cs_n rising edge is detected.
- Strobes: at most one bit of sel_out|sel_dir_out is high in any cycle, and only for one cycle.
- busy = 1 from the synced cs_n falling edge until the FSM returns to IDLE.
- sck and cs_n changing in the same synchronized sample: the cs_n rising edge takes priority and the sck edge is ignored.
- A cs_n falling edge during CHECK/UPDATE/ERROR is honoured on the IDLE cycle that follows; the host must allow ≥ 4 clk between frames.
- rst_n asserted mid-frame aborts the frame with no strobe and no error count. After release the block waits in IDLE for a fresh cs_n falling edge.
  - If cs_n is already low at release, that frame is ignored until cs_n goes high.

Optional Feature:
- Macro: SPI_PARITY_CHECK_EN.
- Defined:
  - Frame length is FRAME_BITS+1; the last bit is even parity over the 24 payload bits.
  - Valid requires count == 25, parity correct and a mapped address; a parity mismatch causes ERROR.
  - Payload is taken from shift[24:1].
- Undefined: 24-bit frames, no parity logic is synthesized, and a 25-bit frame is an overrun error.

Test Plan:
- Frame addr 0x05 data 0x00A5, clean cs_n → data_out=0x00A5; sel_out=0x0020 for exactly one cycle, 2 cycles after synced cs_n rise; frame_err=0.
- Frame addr 0x12 data 0x8003 → sel_dir_out=4'b0100 pulse; data_out=0x8003 (bit15 clear flag passed); sel_out stays 0.
- Frame addr 0x20 data 0x1234 → frame_err pulse; err_cnt 0→1; data_out holds previous value; no strobe.
- 23-bit frame, then 25-bit frame (macro undefined) → two frame_err pulses, err_cnt=2; a following valid frame to addr 0x00 strobes sel_out[0].
- rst_n low after 12 bits of a frame, released while cs_n still low, then cs_n high and a new valid frame to 0x0F → no strobe for the aborted frame; all outputs 0 during reset; sel_out[15] pulses for the new frame.
- SPI_PARITY_CHECK_EN defined: valid 25-bit frame with correct parity → strobe; same frame with the parity bit flipped → frame_err, no strobe; 300 bad frames → err_cnt saturates at 0xFF.
